// File: rtl/latency_stats_collector.sv
// latency_stats_collector
//   Purpose : running statistics (count, min, max, total sum, windowed
//             average) over completed-inference latency samples, a slow-
//             inference alarm, and a registered host read port.
//   Latency : statistics update on the edge that accepts a sample; rd_data
//             and rd_valid appear one cycle after rd_en; avg_valid pulses
//             on the edge that ends the one-cycle EMIT state.
//   Backpressure : none; one sample per cycle is always accepted, and
//             back-to-back samples across a window boundary are not lost.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   lat_valid, lat_in    one-cycle sample strobe and latency value
//   clear_stats          clears statistics/window (not avg/read outputs)
//   rd_en, rd_addr       register read request and select
//   rd_data, rd_valid    registered read response
//   avg_latency, avg_valid  completed-window average and its update pulse
//   lat_alarm            pulse: previous sample exceeded ALARM_THRESH
//
// Optional feature macro: LAT_HIST_EN (eight saturating 16-bit histogram
// bins, readable at rd_addr 8..15). Undefined: addresses 8..15 read 0.

module latency_stats_collector #(
  parameter int LAT_W        = 16,
  parameter int WIN_LOG2     = 4,
  parameter int SUM_W        = 48,
  parameter int ALARM_THRESH = 1000,
  parameter int HIST_SHIFT   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lat_valid,
  input  logic [LAT_W-1:0] lat_in,
  input  logic             clear_stats,
  input  logic             rd_en,
  input  logic [3:0]       rd_addr,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic [LAT_W-1:0] avg_latency,
  output logic             avg_valid,
  output logic             lat_alarm
);

  localparam int WIN_N = 1 << WIN_LOG2;
  localparam int WS_W  = LAT_W + WIN_LOG2;  // wide enough for WIN_N max samples
  localparam int WC_W  = WIN_LOG2 + 1;      // must hold WIN_N itself

  localparam logic [LAT_W-1:0] THRESH_L  = LAT_W'(ALARM_THRESH);
  localparam logic [15:0]      THRESH_16 = 16'(ALARM_THRESH);

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } win_state_t;

  win_state_t       state, state_d;
  logic [31:0]      sample_count;
  logic [LAT_W-1:0] min_lat;
  logic [LAT_W-1:0] max_lat;
  logic [SUM_W-1:0] total_sum;
  logic [WS_W-1:0]  win_sum, win_sum_d;
  logic [WC_W-1:0]  win_cnt, win_cnt_d;
  logic [1:0]       sat_flags;
  logic             emit;

  logic [SUM_W:0]   sum_wide;
  logic [63:0]      sum64;
  logic [31:0]      rd_mux;

  // Carry-out of the total sum tells us when to clamp.
  assign sum_wide = {1'b0, total_sum} + (SUM_W+1)'(lat_in);
  assign sum64    = 64'(total_sum);

  // Window FSM: next state and next window accumulator.
  always_comb begin
    state_d   = state;
    win_sum_d = win_sum;
    win_cnt_d = win_cnt;
    emit      = 1'b0;
    case (state)
      FILL: begin
        if (lat_valid) begin
          win_sum_d = win_sum + WS_W'(lat_in);
          win_cnt_d = win_cnt + 1'b1;
          if (win_cnt == WC_W'(WIN_N - 1)) begin
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        // The average is taken from the full window held this cycle; a
        // sample arriving now opens the next window instead of being lost.
        emit    = 1'b1;
        state_d = FILL;
        if (lat_valid) begin
          win_sum_d = WS_W'(lat_in);
          win_cnt_d = WC_W'(1);
        end else begin
          win_sum_d = '0;
          win_cnt_d = '0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

`ifdef LAT_HIST_EN
  logic [15:0]      hist [8];
  logic [LAT_W-1:0] hist_full;
  logic [2:0]       hist_bin;

  assign hist_full = lat_in >> HIST_SHIFT;
  assign hist_bin  = (hist_full > LAT_W'(7)) ? 3'd7 : hist_full[2:0];

  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      for (int i = 0; i < 8; i++) begin
        hist[i] <= '0;
      end
    end else if (lat_valid && (hist[hist_bin] != 16'hFFFF)) begin
      hist[hist_bin] <= hist[hist_bin] + 16'd1;
    end
  end
`endif

  // Read mux sees pre-update register values, so a read coincident with a
  // sample returns the old statistics.
  always_comb begin
    rd_mux = '0;
    case (rd_addr)
      4'd0: rd_mux = sample_count;
      4'd1: rd_mux = 32'(min_lat);
      4'd2: rd_mux = 32'(max_lat);
      4'd3: rd_mux = 32'(avg_latency);
      4'd4: rd_mux = sum64[31:0];
      4'd5: rd_mux = sum64[63:32];
      4'd6: rd_mux = {28'd0, (state == EMIT), (win_cnt != '0), sat_flags};
      4'd7: rd_mux = {16'd0, THRESH_16};
      default: begin
`ifdef LAT_HIST_EN
        rd_mux = {16'd0, hist[rd_addr[2:0]]};
`else
        rd_mux = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      sample_count <= '0;
      min_lat      <= '1;
      max_lat      <= '0;
      total_sum    <= '0;
      win_sum      <= '0;
      win_cnt      <= '0;
      sat_flags    <= '0;
      avg_latency  <= '0;
      avg_valid    <= 1'b0;
      lat_alarm    <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_mux;
      end

      if (clear_stats) begin
        // Clear wins over a coincident sample, and drops a pending emit.
        state        <= FILL;
        sample_count <= '0;
        min_lat      <= '1;
        max_lat      <= '0;
        total_sum    <= '0;
        win_sum      <= '0;
        win_cnt      <= '0;
        sat_flags    <= '0;
        avg_valid    <= 1'b0;
        lat_alarm    <= 1'b0;
      end else begin
        state     <= state_d;
        win_sum   <= win_sum_d;
        win_cnt   <= win_cnt_d;
        avg_valid <= emit;
        if (emit) begin
          avg_latency <= LAT_W'(win_sum >> WIN_LOG2);
        end
        lat_alarm <= lat_valid && (lat_in > THRESH_L);

        if (lat_valid) begin
          if (&sample_count) begin
            sat_flags[0] <= 1'b1;
          end else begin
            sample_count <= sample_count + 32'd1;
          end

          if (lat_in < min_lat) begin
            min_lat <= lat_in;
          end
          if (lat_in > max_lat) begin
            max_lat <= lat_in;
          end

          if (sum_wide[SUM_W]) begin
            total_sum    <= '1;
            sat_flags[1] <= 1'b1;
          end else begin
            total_sum <= sum_wide[SUM_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_latency_stats_collector.sv
// tb_latency_stats_collector
//   Purpose : randomized + directed stimulus against a queue-based
//             reference model; a monitor pops expected reads, averages and
//             per-cycle alarm values as the DUT presents them.
//   Latency : expectations are pushed before the edge that produces them.
//   Backpressure : none; the DUT accepts every cycle.

module tb_latency_stats_collector;

  localparam int THRESH = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        lat_valid;
  logic [15:0] lat_in;
  logic        clear_stats;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [15:0] avg_latency;
  logic        avg_valid;
  logic        lat_alarm;

  latency_stats_collector dut (
    .clk         (clk),
    .rst         (rst),
    .lat_valid   (lat_valid),
    .lat_in      (lat_in),
    .clear_stats (clear_stats),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .avg_latency (avg_latency),
    .avg_valid   (avg_valid),
    .lat_alarm   (lat_alarm)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q_rd[$];
  logic [15:0] q_avg[$];
  bit          q_alarm[$];

  // Reference model state (plain arithmetic over the sample stream).
  longint unsigned m_cnt;
  int              m_min, m_max, m_avg, m_pend;
  longint unsigned m_sum;
  int              m_win[$];
  bit              m_emit, m_satc, m_sats;
  int              m_hist[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input bit keep_avg);
    m_cnt = 0; m_min = 16'hFFFF; m_max = 0; m_sum = 0;
    m_win.delete(); m_emit = 0; m_satc = 0; m_sats = 0;
    for (int i = 0; i < 8; i++) m_hist[i] = 0;
    if (!keep_avg) m_avg = 0;
  endtask

  function automatic logic [31:0] exp_rd(input int addr);
    logic [31:0] s;
    s = '0;
    case (addr)
      0: s = 32'(m_cnt);
      1: s = 32'(m_min);
      2: s = 32'(m_max);
      3: s = 32'(m_avg);
      4: s = 32'(m_sum & 64'hFFFF_FFFF);
      5: s = 32'(m_sum >> 32);
      6: begin
        s[3] = m_emit;
        s[2] = m_emit || (m_win.size() != 0);
        s[1] = m_sats;
        s[0] = m_satc;
      end
      7: s = 32'(THRESH);
      default: begin
`ifdef LAT_HIST_EN
        s = 32'(m_hist[addr - 8]);
`else
        s = '0;
`endif
      end
    endcase
    return s;
  endfunction

  // One clock of stimulus: queue expectations, update the model, advance.
  task automatic do_cycle(input bit r, input bit v, input int lat,
                          input bit clr, input bit rd, input int addr);
    int tot, b;
    bit alarm;
    rst = r; lat_valid = v; lat_in = 16'(lat); clear_stats = clr;
    rd_en = rd; rd_addr = 4'(addr);
    alarm = 0;
    if (rd && !r) q_rd.push_back(exp_rd(addr));
    if (r) begin
      model_reset(0);
    end else if (clr) begin
      model_reset(1);
    end else begin
      if (m_emit) begin
        m_avg = m_pend;
        q_avg.push_back(16'(m_pend));
      end
      m_emit = 0;
      if (v) begin
        if (m_cnt == 64'hFFFF_FFFF) m_satc = 1; else m_cnt++;
        if (lat < m_min) m_min = lat;
        if (lat > m_max) m_max = lat;
        if (m_sum + longint'(lat) > 64'hFFFF_FFFF_FFFF) begin
          m_sum = 64'hFFFF_FFFF_FFFF; m_sats = 1;
        end else begin
          m_sum += longint'(lat);
        end
        alarm = (lat > THRESH);
        b = lat / 64;
        if (b > 7) b = 7;
        if (m_hist[b] < 65535) m_hist[b]++;
        m_win.push_back(lat);
        if (m_win.size() == 16) begin
          tot = 0;
          foreach (m_win[i]) tot += m_win[i];
          m_pend = tot / 16;
          m_win.delete();
          m_emit = 1;
        end
      end
    end
    q_alarm.push_back(alarm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (q_alarm.size() != 0) chk("lat_alarm", 32'(lat_alarm), 32'(q_alarm.pop_front()));
      if (rd_valid === 1'b1) begin
        if (q_rd.size() == 0) chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
        else chk("rd_data", rd_data, q_rd.pop_front());
      end
      if (avg_valid === 1'b1) begin
        if (q_avg.size() == 0) chk("avg_valid_unexpected", 32'(avg_valid), 32'd0);
        else chk("avg_latency", 32'(avg_latency), 32'(q_avg.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, k;
    rst = 1; lat_valid = 0; lat_in = '0; clear_stats = 0; rd_en = 0; rd_addr = '0;
    model_reset(0);

    repeat (3) do_cycle(1, 0, 0, 0, 0, 0);
    chk("reset_rd_valid",  32'(rd_valid),    32'd0);
    chk("reset_rd_data",   rd_data,          32'd0);
    chk("reset_avg_valid", 32'(avg_valid),   32'd0);
    chk("reset_avg_lat",   32'(avg_latency), 32'd0);
    chk("reset_alarm",     32'(lat_alarm),   32'd0);

    // Empty-state register reads, including the threshold and a histogram slot.
    for (int a = 0; a <= 9; a++) do_cycle(0, 0, 0, 0, 1, a);

    // One full window of 10..160, back to back, then all stats.
    for (int i = 1; i <= 16; i++) do_cycle(0, 1, i * 10, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 1, 6);
    do_cycle(0, 0, 0, 0, 0, 0);
    for (int a = 0; a <= 6; a++) do_cycle(0, 0, 0, 0, 1, a);

    // Threshold boundary.
    do_cycle(0, 1, 1001, 0, 0, 0);
    do_cycle(0, 1, 1000, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0);

    // Clear coincident with a sample discards it.
    do_cycle(0, 1, 50, 1, 0, 0);
    for (int a = 0; a <= 6; a++) do_cycle(0, 0, 0, 0, 1, a);

    // Read coincident with the 3rd sample returns the old count.
    do_cycle(0, 1, 7, 0, 0, 0);
    do_cycle(0, 1, 8, 0, 0, 0);
    do_cycle(0, 1, 9, 0, 1, 0);
    do_cycle(0, 0, 0, 0, 1, 0);

    // Histogram-bin samples.
    do_cycle(0, 0, 0, 1, 0, 0);
    do_cycle(0, 1, 5, 0, 0, 0);
    do_cycle(0, 1, 70, 0, 0, 0);
    do_cycle(0, 1, 70, 0, 0, 0);
    do_cycle(0, 1, 5000, 0, 0, 0);
    for (int a = 8; a <= 15; a++) do_cycle(0, 0, 0, 0, 1, a);

    // Randomized traffic.
    for (int n = 0; n < 700; n++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: lat = 0;
        1: lat = 65535;
        2: lat = THRESH + $urandom_range(0, 1);
        default: lat = $urandom_range(0, 1500);
      endcase
      do_cycle(0, ($urandom_range(0, 3) != 0), lat, ($urandom_range(0, 63) == 0),
               $urandom_range(0, 1), $urandom_range(0, 15));
    end

    // Reset mid-operation with a coincident read and sample: both dropped.
    do_cycle(1, 1, 1234, 0, 1, 3);
    for (int a = 0; a <= 6; a++) do_cycle(0, 0, 0, 0, 1, a);
    for (int i = 0; i < 20; i++) do_cycle(0, 1, $urandom_range(0, 2000), 0, 1, $urandom_range(0, 7));

    // Drain with a bounded number of idle cycles.
    for (int i = 0; i < 20 && (q_rd.size() != 0 || q_avg.size() != 0); i++)
      do_cycle(0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 0, 0, 0);
    chk("rd_queue_drained",  32'(q_rd.size()),  32'd0);
    chk("avg_queue_drained", 32'(q_avg.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/latency_stats_collector.md
Name: latency_stats_collector

Overview:
- Downstream consumer of the BNN performance-monitor stage. Takes each completed-inference latency sample and keeps running statistics: count, min, max, total sum, and a windowed average.
- Raises a threshold alarm on slow inferences.
- Exposes all statistics through a registered read port for the host/debug interface.

Parameters:
- LAT_W, 16, width of incoming latency sample
- WIN_LOG2, 4, average window = 2^WIN_LOG2 samples
- SUM_W, 48, width of total latency accumulator
- ALARM_THRESH, 1000, alarm when latency strictly greater than this value
- HIST_SHIFT, 6, histogram bin = latency >> HIST_SHIFT (used only with the optional feature)

Ports:
- clk  input  1  single clock, all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- lat_valid  input  1  one-cycle strobe: lat_in holds a new completed-inference latency
- lat_in  input  LAT_W  latency sample in cycles
- clear_stats  input  1  synchronous clear of all statistics
- rd_en  input  1  read request
- rd_addr  input  4  read register select
- rd_data  output  32  read data, registered
- rd_valid  output  1  high one cycle after rd_en
- avg_latency  output  LAT_W  most recent completed-window average
- avg_valid  output  1  one-cycle pulse when avg_latency updates
- lat_alarm  output  1  one-cycle pulse, sample exceeded ALARM_THRESH

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset / clear values: sample_count=0, min_lat=all-ones, max_lat=0, total_sum=0, win_sum=0, win_cnt=0, avg_latency=0, avg_valid=0, lat_alarm=0, rd_data=0, rd_valid=0, sat_flags=0.
- rst mid-operation restores all reset values on the next edge. An in-flight read is dropped (rd_valid=0).
- clear_stats clears the statistics and window state, but not avg_latency, rd_data or rd_valid.
  - clear_stats has priority over lat_valid in the same cycle; that sample is discarded.
- On a lat_valid edge, all registers update together:
  - sample_count += 1, saturating at 2^32-1; sat_flags[0] set when saturated.
  - min_lat = min(min_lat, lat_in); max_lat = max(max_lat, lat_in). Equal values leave them unchanged.
  - total_sum += lat_in, saturating at 2^SUM_W-1; sat_flags[1] set when saturated.
  - lat_alarm = 1 next cycle if lat_in > ALARM_THRESH, else 0.
- Window state machine, states FILL and EMIT:
  - FILL: win_sum += lat_in and win_cnt += 1 per sample. win_sum is LAT_W+WIN_LOG2 bits, so it never overflows.
  - When a sample makes win_cnt reach 2^WIN_LOG2, go to EMIT.
  - EMIT lasts one cycle: avg_latency = win_sum >> WIN_LOG2 (truncating), avg_valid=1, win_sum and win_cnt return to 0, then back to FILL.
  - A lat_valid arriving during EMIT is the first sample of the new window (win_sum=lat_in, win_cnt=1). No sample is lost, even with back-to-back lat_valid.
- avg_valid, lat_alarm and rd_valid are single-cycle pulses.
- Read port: one-cycle latency. rd_data is captured from register values before the same-edge statistics update, so a read coincident with lat_valid returns the old value.
- Read map (all values zero-extended):
  - 0: sample_count
  - 1: min_lat
  - 2: max_lat
  - 3: avg_latency
  - 4: total_sum[31:0]
  - 5: total_sum[SUM_W-1:32]
  - 6: {28'b0, state==EMIT, win_cnt!=0, sat_flags[1:0]}
  - 7: {16'b0, ALARM_THRESH[15:0]}
  - 8-15: histogram bins (optional feature), otherwise 0
- rd_en with no preceding sample: min reads 0x0000FFFF, which marks "no data".

Optional Feature:
- Macro: LAT_HIST_EN.
- Defined: eight 16-bit histogram counters.
  - On each accepted sample, bin = lat_in >> HIST_SHIFT, clamped to 7; that bin increments, saturating at 0xFFFF.
  - Bins are cleared by rst and clear_stats.
  - Readable at rd_addr 8+bin.
- Not defined: no histogram logic is instantiated; rd_addr 8-15 return 0.

Test Plan:
- Reset, then read addresses 0-6 -> count 0, min 0xFFFF, max 0, avg 0, sum 0/0, status 0; rd_valid one cycle after each rd_en.
- 16 back-to-back samples of value 10,20,...,160 with WIN_LOG2=4 -> avg_valid pulses once, avg_latency=85, count=16, min=10, max=160, total_sum=1360.
- Sample 1001, then 1000, with ALARM_THRESH=1000 -> lat_alarm pulses only after 1001.
- clear_stats asserted together with lat_valid(50) -> all statistics reset; the sample is not counted (count=0, min=0xFFFF).
- rd_en addr 0 in the same cycle as the 3rd lat_valid -> rd_data=2; a following read returns 3.
- With LAT_HIST_EN and HIST_SHIFT=6, samples 5, 70, 70, 5000 -> bin0=1, bin1=2, bin7=1. Without the macro, addr 9 reads 0.
